// File: rtl/bnn_pkg.sv
// Shared types and sizing helpers for the BNN conv datapath and its feeders.
package bnn_pkg;

  // Default geometry; the conv core and the loader must be built from these same values.
  localparam int DEF_IC       = 8;
  localparam int DEF_IMG_SIZE = 30;

  // Loader states: filling the image, discarding an over-long frame, holding a frame for the core.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    ARMED = 2'd2
  } fmap_ld_state_t;

  // Number of packed bytes needed to carry one full feature map.
  function automatic int calcNbytes(input int ic, input int imgSize);
    return (ic * imgSize * imgSize + 7) / 8;
  endfunction

endpackage

// File: rtl/fmap_loader_if.sv
// Byte-stream input and conv-core handshake of the feature-map loader.
interface fmap_loader_if
  import bnn_pkg::*;
#(
  parameter int IC       = DEF_IC,
  parameter int IMG_SIZE = DEF_IMG_SIZE
) ();

  localparam int PIX = IMG_SIZE * IMG_SIZE;

  logic [7:0]     s_data;
  logic           s_valid;
  logic           s_last;
  logic           s_ready;
  logic [PIX-1:0] img_out [0:IC-1];
  logic           conv_start;
  logic           conv_done;
  logic           frame_done;
  logic           frame_err;

  // The loader itself: consumes the stream, drives the image and the core handshake.
  modport slave (
    input  s_data, s_valid, s_last, conv_done,
    output s_ready, img_out, conv_start, frame_done, frame_err
  );

  // The environment: byte source plus conv core.
  modport master (
    output s_data, s_valid, s_last, conv_done,
    input  s_ready, img_out, conv_start, frame_done, frame_err
  );

endinterface

// File: rtl/fmap_loader.sv
// Assembles one binary feature map from a packed byte stream and holds it
// stable for the conv core until the core reports completion.
module fmap_loader
  import bnn_pkg::*;
#(
  parameter int IC       = DEF_IC,
  parameter int IMG_SIZE = DEF_IMG_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  fmap_loader_if.slave  bus
);

  localparam int PIX    = IMG_SIZE * IMG_SIZE;
  localparam int NBITS  = IC * PIX;
  localparam int NBYTES = calcNbytes(IC, IMG_SIZE);
  localparam int CW     = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  fmap_ld_state_t state_q;
  logic [CW-1:0]    byteCnt_q;
  logic [NBITS-1:0] img_q;
  logic [NBITS-1:0] img_d;
  logic             convStart_q;
  logic             frameDone_q;
  logic             frameErr_q;
  logic             sReady;
  logic             accept;

  assign sReady = (state_q == LOAD) || (state_q == DRAIN);
  assign accept = bus.s_valid && sReady;

  // Image with the current byte dropped into its slot; bits past the frame end are clipped.
  always_comb begin
    img_d = img_q;
    for (int b = 0; b < 8; b++) begin
      if (int'(byteCnt_q) * 8 + b < NBITS) begin
        img_d[int'(byteCnt_q) * 8 + b] = bus.s_data[b];
      end
    end
  end

  // Frame state machine: counts bytes, writes the image, arms and releases the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      byteCnt_q   <= '0;
      img_q       <= '0;
      convStart_q <= 1'b0;
      frameDone_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (state_q)
        LOAD: begin
          if (accept) begin
            img_q <= img_d;
            if (byteCnt_q == LAST_IDX) begin
              byteCnt_q <= '0;
              if (bus.s_last) begin
                state_q     <= ARMED;
                convStart_q <= 1'b1;
              end else begin
                state_q    <= DRAIN;
                frameErr_q <= 1'b1;
              end
            end else if (bus.s_last) begin
              byteCnt_q  <= '0;
              frameErr_q <= 1'b1;
            end else begin
              byteCnt_q <= byteCnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (accept && bus.s_last) begin
            state_q <= LOAD;
          end
        end
        ARMED: begin
          if (bus.conv_done) begin
            state_q     <= LOAD;
            convStart_q <= 1'b0;
            frameDone_q <= 1'b1;
            byteCnt_q   <= '0;
          end
        end
        default: begin
          state_q     <= LOAD;
          byteCnt_q   <= '0;
          convStart_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready    = sReady;
  assign bus.conv_start = convStart_q;
  assign bus.frame_done = frameDone_q;
  assign bus.frame_err  = frameErr_q;

  for (genvar c = 0; c < IC; c++) begin : g_ch
    assign bus.img_out[c] = img_q[c*PIX +: PIX];
  end

endmodule

// File: tb/tb_fmap_loader.sv
// Self-checking bench for fmap_loader: a 2x4x4 instance driven with random
// frames and a 1x3x3 instance exercising the clipped final byte.
module tb_fmap_loader;

  typedef logic [7:0] byteQ_t[$];

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fmap_loader_if #(.IC(2), .IMG_SIZE(4)) ifA ();
  fmap_loader_if #(.IC(1), .IMG_SIZE(3)) ifB ();

  fmap_loader #(.IC(2), .IMG_SIZE(4)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA.slave)
  );

  fmap_loader #(.IC(1), .IMG_SIZE(3)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB.slave)
  );

  // Free-running clock shared by both instances.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference image: global bit k of the frame lands on channel k/pix, pixel k%pix.
  function automatic logic [63:0] modelChannel(input byteQ_t q, input int c, input int pix,
                                               input int nbits);
    logic [63:0] r;
    logic [7:0]  bt;
    r = '0;
    for (int p = 0; p < pix; p++) begin
      int k;
      k = c * pix + p;
      if (k < nbits && (k / 8) < q.size()) begin
        bt   = q[k / 8];
        r[p] = bt[k % 8];
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One byte on instance A, optionally after a random idle gap, waiting (bounded) for s_ready.
  task automatic applyStimulus(input logic [7:0] d, input logic last, input bit gaps);
    int waitCnt;
    @(negedge clk);
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    waitCnt = 0;
    while (!ifA.s_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("sReadyBeforeByte", {63'd0, ifA.s_ready}, 64'd1);
    ifA.s_data  = d;
    ifA.s_last  = last;
    ifA.s_valid = 1'b1;
    @(posedge clk);
    #1;
    ifA.s_valid = 1'b0;
    ifA.s_last  = 1'b0;
  endtask

  task automatic sendFrame(input byteQ_t q, input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      if (i == q.size() - 1) checkOutput("convStartLowBeforeLast", {63'd0, ifA.conv_start}, 64'd0);
      applyStimulus(q[i], (i == q.size() - 1), gaps);
    end
  endtask

  task automatic checkArmed(input byteQ_t q, input string tag);
    checkOutput({tag, "_img0"}, 64'(ifA.img_out[0]), modelChannel(q, 0, 16, 32));
    checkOutput({tag, "_img1"}, 64'(ifA.img_out[1]), modelChannel(q, 1, 16, 32));
    checkOutput({tag, "_convStart"}, {63'd0, ifA.conv_start}, 64'd1);
    checkOutput({tag, "_sReady"}, {63'd0, ifA.s_ready}, 64'd0);
  endtask

  task automatic releaseCore(input string tag);
    @(negedge clk);
    ifA.conv_done = 1'b1;
    @(posedge clk);
    #1;
    ifA.conv_done = 1'b0;
    checkOutput({tag, "_convStartFall"}, {63'd0, ifA.conv_start}, 64'd0);
    checkOutput({tag, "_frameDone"}, {63'd0, ifA.frame_done}, 64'd1);
    checkOutput({tag, "_sReadyBack"}, {63'd0, ifA.s_ready}, 64'd1);
    @(posedge clk);
    #1;
    checkOutput({tag, "_frameDonePulse"}, {63'd0, ifA.frame_done}, 64'd0);
  endtask

  function automatic byteQ_t randomFrame(input int n);
    byteQ_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  // Directed sequence with randomized payloads.
  initial begin
    byteQ_t q;
    byteQ_t good;
    byteQ_t qb;
    logic [15:0] held0;
    logic [15:0] held1;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ifA.s_data = 8'd0; ifA.s_valid = 1'b0; ifA.s_last = 1'b0; ifA.conv_done = 1'b0;
    ifB.s_data = 8'd0; ifB.s_valid = 1'b0; ifB.s_last = 1'b0; ifB.conv_done = 1'b0;

    #1;
    checkOutput("rst_convStart", {63'd0, ifA.conv_start}, 64'd0);
    checkOutput("rst_frameDone", {63'd0, ifA.frame_done}, 64'd0);
    checkOutput("rst_frameErr", {63'd0, ifA.frame_err}, 64'd0);
    checkOutput("rst_img0", 64'(ifA.img_out[0]), 64'd0);
    checkOutput("rst_img1", 64'(ifA.img_out[1]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("postRst_sReady", {63'd0, ifA.s_ready}, 64'd1);

    $display("[TB] basic frame");
    q = {8'h01, 8'h80, 8'hFF, 8'h00};
    sendFrame(q, 1'b0);
    checkOutput("basic_img0_const", 64'(ifA.img_out[0]), 64'h8001);
    checkOutput("basic_img1_const", 64'(ifA.img_out[1]), 64'h00FF);
    checkArmed(q, "basic");
    releaseCore("basic");
    sendFrame(q, 1'b0);
    checkArmed(q, "reload");
    releaseCore("reload");

    $display("[TB] conv_done outside ARMED is ignored");
    @(negedge clk);
    ifA.conv_done = 1'b1;
    @(posedge clk);
    #1;
    ifA.conv_done = 1'b0;
    checkOutput("strayDone_frameDone", {63'd0, ifA.frame_done}, 64'd0);
    checkOutput("strayDone_sReady", {63'd0, ifA.s_ready}, 64'd1);

    $display("[TB] random frames with gaps");
    for (int f = 0; f < 4; f++) begin
      q = randomFrame(4);
      sendFrame(q, 1'b1);
      checkArmed(q, "rand");
      releaseCore("rand");
    end

    $display("[TB] short frame");
    q = randomFrame(2);
    applyStimulus(q[0], 1'b0, 1'b0);
    applyStimulus(q[1], 1'b1, 1'b0);
    checkOutput("short_frameErr", {63'd0, ifA.frame_err}, 64'd1);
    checkOutput("short_convStart", {63'd0, ifA.conv_start}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("short_frameErrPulse", {63'd0, ifA.frame_err}, 64'd0);
    good = randomFrame(4);
    sendFrame(good, 1'b0);
    checkArmed(good, "afterShort");
    releaseCore("afterShort");

    $display("[TB] long frame");
    q = randomFrame(6);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(q[i], (i == 5), 1'b1);
      if (i == 3) checkOutput("long_frameErr", {63'd0, ifA.frame_err}, 64'd1);
    end
    checkOutput("long_convStart", {63'd0, ifA.conv_start}, 64'd0);
    checkOutput("long_frameErrOnce", {63'd0, ifA.frame_err}, 64'd0);
    good = randomFrame(4);
    sendFrame(good, 1'b1);
    checkArmed(good, "afterLong");

    $display("[TB] s_valid held during ARMED");
    held0 = ifA.img_out[0];
    held1 = ifA.img_out[1];
    @(negedge clk);
    ifA.s_data  = ~good[0];
    ifA.s_last  = 1'b1;
    ifA.s_valid = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("hold_img0", 64'(ifA.img_out[0]), 64'(held0));
    checkOutput("hold_img1", 64'(ifA.img_out[1]), 64'(held1));
    checkOutput("hold_img0_model", 64'(ifA.img_out[0]), modelChannel(good, 0, 16, 32));
    checkOutput("hold_convStart", {63'd0, ifA.conv_start}, 64'd1);
    checkOutput("hold_sReady", {63'd0, ifA.s_ready}, 64'd0);
    ifA.s_valid = 1'b0;
    ifA.s_last  = 1'b0;
    releaseCore("afterHold");

    $display("[TB] reset mid-frame");
    q = randomFrame(2);
    applyStimulus(q[0], 1'b0, 1'b0);
    applyStimulus(q[1], 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstMid_img0", 64'(ifA.img_out[0]), 64'd0);
    checkOutput("rstMid_convStart", {63'd0, ifA.conv_start}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    good = randomFrame(4);
    sendFrame(good, 1'b0);
    checkArmed(good, "afterRstMid");

    $display("[TB] reset while ARMED");
    @(negedge clk);
    ifA.conv_done = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("rstArmed_convStart", {63'd0, ifA.conv_start}, 64'd0);
    checkOutput("rstArmed_img0", 64'(ifA.img_out[0]), 64'd0);
    checkOutput("rstArmed_img1", 64'(ifA.img_out[1]), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rstArmed_frameDone", {63'd0, ifA.frame_done}, 64'd0);
    @(negedge clk);
    ifA.conv_done = 1'b0;
    rst = 1'b0;
    good = randomFrame(4);
    sendFrame(good, 1'b1);
    checkArmed(good, "afterRstArmed");
    releaseCore("afterRstArmed");

    $display("[TB] non-byte-aligned frame");
    qb = {8'hAA, 8'hFF};
    @(negedge clk);
    checkOutput("b_sReady", {63'd0, ifB.s_ready}, 64'd1);
    ifB.s_data  = qb[0];
    ifB.s_valid = 1'b1;
    @(negedge clk);
    ifB.s_data  = qb[1];
    ifB.s_last  = 1'b1;
    @(posedge clk);
    #1;
    ifB.s_valid = 1'b0;
    ifB.s_last  = 1'b0;
    checkOutput("b_img0", 64'(ifB.img_out[0]), modelChannel(qb, 0, 9, 9));
    checkOutput("b_img0_const", 64'(ifB.img_out[0]), 64'h1AA);
    checkOutput("b_convStart", {63'd0, ifB.conv_start}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fmap_loader.md
Name: fmap_loader

Overview:
- Producer side of the conv core's level handshake.
- Assembles one binary feature map (IC channels of IMG_SIZE x IMG_SIZE bits) from a packed byte stream arriving from the host/SPI front end.
- Presents the feature map on a parallel bus and raises conv_start. It then holds the image stable until the conv core signals completion, releases the core, and accepts the next frame.

Parameters:
IC, 8, number of input channels
IMG_SIZE, 30, feature-map side length in pixels
NBITS, IC*IMG_SIZE*IMG_SIZE, derived; total bits per frame
NBYTES, (NBITS+7)/8, derived; bytes per frame

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_data  in  8  packed pixel byte
s_valid  in  1  byte valid
s_last  in  1  marks final byte of a frame
s_ready  out  1  loader can accept a byte
img_out  out  [IMG_SIZE*IMG_SIZE-1:0] x [0:IC-1]  per-channel binary image to conv core
conv_start  out  1  level; high while img_out is valid and the core may run (drives core data_in_ready)
conv_done  in  1  one-cycle pulse from core (core data_out_ready)
frame_done  out  1  one-cycle pulse when the core finishes the held frame
frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=LOAD, byte counter=0, img_out all 0, conv_start=0, frame_done=0, frame_err=0. s_ready=1 once rst deasserts. Reset mid-frame or mid-convolution discards everything.
- Handshake: a byte is accepted on a clk edge where s_valid && s_ready. s_ready = (state==LOAD || state==DRAIN).
- Bit mapping: global bit k = byte_index*8 + b (b=0 is LSB). Channel c = k / (IMG_SIZE*IMG_SIZE); pixel p = k % (IMG_SIZE*IMG_SIZE); img_out[c][p] = s_data[b].
  - Pixel order is row-major (p = row*IMG_SIZE+col), channel-major overall.
  - Bits with k >= NBITS in the final byte are ignored.
- Storage: a flat NBITS register. An accepted byte writes up to 8 consecutive bits, clipped at NBITS, and may straddle a channel boundary.
- States:
  - LOAD: accept bytes; counter increments per accepted byte.
    - Accepted byte with counter==NBYTES-1 and s_last=1 -> ARMED.
    - Accepted byte with counter<NBYTES-1 and s_last=1 (short frame) -> frame_err pulse, counter=0, stay LOAD.
    - Accepted byte with counter==NBYTES-1 and s_last=0 (long frame) -> frame_err pulse, counter=0, go DRAIN.
  - DRAIN: accept and discard bytes; no writes. Accepted byte with s_last=1 -> LOAD.
  - ARMED: conv_start=1, s_ready=0, img_out frozen.
    - conv_done sampled high -> next cycle conv_start=0, frame_done=1 for one cycle, counter=0, state LOAD.
    - conv_done in any other state is ignored.
- Latency:
  - conv_start rises in the cycle after the final-byte handshake; the final byte's bits are already visible in img_out in that cycle.
  - conv_start falls in the cycle after conv_done.
- Core release: conv_start stays low for at least one cycle between frames, because a new frame needs at least one byte in LOAD. This guarantees the core resets its internal state.
- Simultaneous events:
  - s_valid asserted during ARMED: not accepted; the upstream source must hold the byte.
  - conv_done coincident with rst: rst wins.
- img_out may change during LOAD. The core is held in reset then (conv_start=0), so this is harmless.

Decomposition:
- Shared package bnn_pkg: the state enum fmap_ld_state_t (LOAD, DRAIN, ARMED) and a function computing NBYTES from IC and IMG_SIZE.
- The conv core and this loader must use identical IC and IMG_SIZE defaults from the top level.
- No sub-module: the clipped byte write and the state machine fit in one module.

Test Plan:
- Basic load (IC=2, IMG_SIZE=4, 4 bytes): bytes 0x01,0x80,0xFF,0x00, s_last on 4th -> img_out[0]=16'h8001, img_out[1]=16'h00FF; conv_start=1 and s_ready=0 one cycle after 4th handshake.
- Release: in ARMED, pulse conv_done once -> conv_start=0 next cycle with frame_done=1 for exactly one cycle; s_ready=1; a second identical frame reloads and re-arms.
- Non-byte-aligned frame (IC=1, IMG_SIZE=3, 2 bytes): 0xAA then 0xFF, s_last -> img_out[0]=9'h1AA; bits 7:1 of byte 2 ignored.
- Short and long frames (IC=2, IMG_SIZE=4):
  - s_last on byte 2 -> frame_err pulse, conv_start stays 0.
  - 6-byte frame, s_last on byte 6 -> frame_err at byte 4, bytes 5-6 accepted and dropped, then a correct 4-byte frame arms with the expected image.
- Backpressure: random s_valid gaps give the same result as scenario 1. s_valid held high during ARMED for 10 cycles -> no acceptance, img_out unchanged.
- Reset mid-operation: rst asserted after 2 bytes, and separately while ARMED -> img_out=0, conv_start=0 immediately (async); the next full frame loads correctly.
